cla_mul_seq: RTL and testbench



---
 rtl/cla_mul_seq.sv | 96 +++++++++
 tb/tb_cla_mul_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_mul_seq.sv
// Radix-2 shift-add multiplier controller that time-shares an external
// combinational carry-lookahead adder to form a WIDTH x WIDTH unsigned product.
module cla_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_iter;

  // A new request is taken in IDLE or DONE only; flush always wins.
  assign accept    = start && !flush && (state != RUN);
  assign last_iter = (state == RUN) && (cnt == LAST_CNT);

  // Carry-out of the partial-sum add becomes the new MSB of hi; the bit
  // falling off hi moves into lo as the multiplier bits are consumed.
  assign hi_nxt = {add_cout, add_sum[WIDTH-1:1]};
  assign lo_nxt = {add_sum[0], lo[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        add_a = hi;
        add_b = lo[0] ? mcand : '0;
        if (flush)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = accept ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        mcand <= op_a;
        hi    <= '0;
        lo    <= op_b;
        cnt   <= '0;
      end else if (state == RUN) begin
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last_iter) product <= {hi_nxt, lo_nxt};
      end
    end
  end

endmodule

// File: tb/tb_cla_mul_seq.sv
// Directed bench for cla_mul_seq with a behavioural CLA adder and a product
// scoreboard filled at start acceptance and drained on each done pulse.
module tb_cla_mul_seq;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               flush;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  int n_assert = 0;
  int n_fail   = 0;
  bit carry_seen;
  logic [31:0] sb[$];

  cla_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush    (flush),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request, let it be sampled, then drop start.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat0 = samples already taken since the accepting edge (all expected busy).
  task automatic wait_done(input string tag, input int lat0);
    int lat   = lat0;
    int nbusy = lat0;
    if (busy && add_cout) carry_seen = 1'b1;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) nbusy++;
      if (busy && add_cout) carry_seen = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd17);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd16);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    if (sb.size() > 0) chk({tag, "_product"}, product, sb.pop_front());
    else chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
  endtask

  task automatic count_dones(input string tag, input int cycles, input int exp);
    int nd = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) nd++;
    end
    chk(tag, 32'(nd), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;
    carry_seen = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Basic multiply
    start_op(16'd3, 16'd5);
    sb.push_back(32'h0000_000F);
    chk("basic_busy_first", 32'(busy), 32'd1);
    wait_done("basic", 1);
    tick();
    chk("basic_done_pulse", 32'(done), 32'd0);
    chk("basic_product_held", product, 32'h0000_000F);
    chk("idle_add_a", 32'(add_a), 32'd0);

    // Carry path through add_cout
    carry_seen = 1'b0;
    start_op(16'hFFFF, 16'hFFFF);
    sb.push_back(32'hFFFE_0001);
    wait_done("carry", 1);
    chk("carry_cout_seen", 32'(carry_seen), 32'd1);
    tick();

    // Flush mid-run: no done, product keeps the previous result
    start_op(16'h00FF, 16'h0101);
    for (int i = 0; i < 7; i++) tick();
    chk("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_after", 32'(busy), 32'd0);
    chk("flush_done_after", 32'(done), 32'd0);
    chk("flush_product_kept", product, 32'hFFFE_0001);
    count_dones("flush_no_done", 20, 0);
    chk("flush_product_still", product, 32'hFFFE_0001);
    start_op(16'd2, 16'd9);
    sb.push_back(32'h0000_0012);
    wait_done("after_flush", 1);
    tick();

    // Zero operand plus ignored start while busy
    start_op(16'h1234, 16'h0000);
    sb.push_back(32'h0000_0000);
    tick();
    tick();
    tick();
    op_a  = 16'd7;
    op_b  = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignored_start_busy", 32'(busy), 32'd1);
    wait_done("zero", 5);
    count_dones("zero_single_done", 20, 0);
    chk("zero_product_held", product, 32'd0);

    // Back-to-back: new start accepted in the DONE cycle
    start_op(16'd5, 16'd6);
    sb.push_back(32'd30);
    wait_done("b2b_first", 1);
    start_op(16'h8000, 16'h0002);
    sb.push_back(32'h0001_0000);
    chk("b2b_busy_immediate", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done("b2b_second", 1);
    tick();

    // Asynchronous reset on the 5th RUN cycle
    start_op(16'hABCD, 16'h1234);
    for (int i = 0; i < 4; i++) tick();
    chk("arst_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_product", product, 32'd0);
    chk("arst_add_a", 32'(add_a), 32'd0);
    chk("arst_add_b", 32'(add_b), 32'd0);
    tick();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    count_dones("post_rst_no_done", 10, 0);
    start_op(16'd3, 16'd7);
    sb.push_back(32'd21);
    wait_done("post_rst", 1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
